// File: rtl/core_lsu_mmio_if.sv
// Core-side request/response, data-memory and stdio channel signals of the load/store unit.
// The LSU takes the slave modport; the core/memory/stdio side takes the master modport.
interface core_lsu_mmio_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int N_IO   = 1
);
    logic                   req_val_i;
    logic                   req_wen_i;
    logic [ADDR_W-1:0]      req_addr_i;
    logic [DATA_W-1:0]      req_data_i;
    logic                   req_rdy_o;
    logic                   rsp_val_o;
    logic [DATA_W-1:0]      rsp_data_o;
    logic                   mem_val_o;
    logic                   mem_wen_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [DATA_W-1:0]      mem_wdata_o;
    logic                   mem_rdy_i;
    logic [DATA_W-1:0]      mem_rdata_i;
    logic [N_IO-1:0]        in_val_i;
    logic [N_IO*DATA_W-1:0] in_data_i;
    logic [N_IO-1:0]        in_rdy_o;
    logic [N_IO-1:0]        out_val_o;
    logic [N_IO*DATA_W-1:0] out_data_o;
    logic [N_IO-1:0]        out_rdy_i;

    modport slave (
        input  req_val_i, req_wen_i, req_addr_i, req_data_i,
        input  mem_rdy_i, mem_rdata_i, in_val_i, in_data_i, out_rdy_i,
        output req_rdy_o, rsp_val_o, rsp_data_o,
        output mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o,
        output in_rdy_o, out_val_o, out_data_o
    );

    modport master (
        output req_val_i, req_wen_i, req_addr_i, req_data_i,
        output mem_rdy_i, mem_rdata_i, in_val_i, in_data_i, out_rdy_i,
        input  req_rdy_o, rsp_val_o, rsp_data_o,
        input  mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o,
        input  in_rdy_o, out_val_o, out_data_o
    );
endinterface

// File: rtl/core_lsu_mmio.sv
// Load/store unit: top N_IO addresses map to stdio channels with input prefetch FIFOs,
// everything else goes to data memory; loads return through a registered one-cycle path.
module core_lsu_mmio #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int N_IO     = 1,
    parameter int IN_DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    core_lsu_mmio_if.slave bus
);
    localparam int PTR_W = $clog2(IN_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(IN_DEPTH);

    logic [DATA_W-1:0] fifo_mem [N_IO][IN_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [N_IO];
    logic [PTR_W-1:0]  wr_ptr_q [N_IO];
    logic [CNT_W-1:0]  cnt_q    [N_IO];

    logic [N_IO-1:0]        hit, push, pop, in_rdy;
    logic                   io_hit, req_rdy, load_acc;
    logic [DATA_W-1:0]      io_head;
    logic                   mem_val, mem_wen;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [N_IO-1:0]        out_val;
    logic [N_IO*DATA_W-1:0] out_data;

    logic              rsp_pend_q, rsp_src_q;
    logic [DATA_W-1:0] rsp_io_q;

    // Address decode and request routing; at most one target is driven per cycle.
    always_comb begin
        hit       = '0;
        io_head   = '0;
        req_rdy   = 1'b0;
        mem_val   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        out_val   = '0;
        out_data  = '0;
        for (int k = 0; k < N_IO; k++) begin
            if (bus.req_addr_i == ADDR_TOP - ADDR_W'(k)) hit[k] = 1'b1;
        end
        io_hit = |hit;
        if (bus.req_val_i) begin
            if (!io_hit) begin
                mem_val   = 1'b1;
                mem_wen   = bus.req_wen_i;
                mem_addr  = bus.req_addr_i;
                mem_wdata = bus.req_data_i;
                req_rdy   = bus.mem_rdy_i;
            end else begin
                for (int k = 0; k < N_IO; k++) begin
                    if (hit[k]) begin
                        if (bus.req_wen_i) begin
                            out_val[k]                    = 1'b1;
                            out_data[k*DATA_W +: DATA_W]  = bus.req_data_i;
                            req_rdy                       = bus.out_rdy_i[k];
                        end else begin
                            req_rdy = (cnt_q[k] != '0);
                            io_head = fifo_mem[k][rd_ptr_q[k]];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_IO; k++) begin
            in_rdy[k] = (cnt_q[k] != CNT_FULL);
        end
    end

    assign load_acc = bus.req_val_i && req_rdy && !bus.req_wen_i;
    assign pop      = load_acc ? hit : '0;
    assign push     = bus.in_val_i & in_rdy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_IO; k++) begin
                rd_ptr_q[k] <= '0;
                wr_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < N_IO; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                case ({push[k], pop[k]})
                    2'b10:   cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    2'b01:   cnt_q[k] <= cnt_q[k] - CNT_W'(1);
                    default: cnt_q[k] <= cnt_q[k];
                endcase
            end
        end
    end

    // Storage needs no reset: the count alone decides what is readable.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_IO; k++) begin
            if (push[k]) fifo_mem[k][wr_ptr_q[k]] <= bus.in_data_i[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_pend_q <= 1'b0;
            rsp_src_q  <= 1'b0;
            rsp_io_q   <= '0;
        end else begin
            rsp_pend_q <= load_acc;
            rsp_src_q  <= io_hit;
            if (load_acc && io_hit) rsp_io_q <= io_head;
        end
    end

    assign bus.req_rdy_o   = req_rdy;
    assign bus.mem_val_o   = mem_val;
    assign bus.mem_wen_o   = mem_wen;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.out_val_o   = out_val;
    assign bus.out_data_o  = out_data;
    assign bus.in_rdy_o    = in_rdy;
    assign bus.rsp_val_o   = rsp_pend_q;
    assign bus.rsp_data_o  = rsp_pend_q ? (rsp_src_q ? rsp_io_q : bus.mem_rdata_i) : '0;
endmodule

// File: tb/tb_core_lsu_mmio.sv
// Self-checking bench for core_lsu_mmio with two stdio channels; load responses are
// checked against a queue of expected data and arrival cycles.
module tb_core_lsu_mmio;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NIO = 2;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    core_lsu_mmio_if #(.DATA_W(DW), .ADDR_W(AW), .N_IO(NIO)) bus ();

    core_lsu_mmio #(.DATA_W(DW), .ADDR_W(AW), .N_IO(NIO), .IN_DEPTH(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Response scoreboard: every pulse must match the oldest expected entry, data and cycle.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (!rst_i) begin
            if (bus.rsp_val_o) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rsp_unexpected: got data %h at cycle %0d, want no response", bus.rsp_data_o, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.rsp_data_o !== e.data || cyc != e.cyc) begin
                        tests_failed++;
                        $display("FAIL rsp_data: got %h at cycle %0d, want %h at cycle %0d", bus.rsp_data_o, cyc, e.data, e.cyc);
                    end
                end
            end else if (bus.rsp_data_o !== '0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rsp_idle_data: got %h, want 0000", bus.rsp_data_o);
            end
        end
    end

    task automatic idle();
        bus.req_val_i   = 1'b0;
        bus.req_wen_i   = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        bus.mem_rdy_i   = 1'b1;
        bus.mem_rdata_i = 16'hDEAD;
        bus.in_val_i    = '0;
        bus.in_data_i   = '0;
        bus.out_rdy_i   = '1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if ({bus.rsp_val_o, bus.rsp_data_o, bus.in_rdy_o} !== {1'b0, 16'h0000, 2'b11}) begin
            tests_failed++;
            $display("FAIL reset_state: got val=%b data=%h in_rdy=%b, want 0 0000 11", bus.rsp_val_o, bus.rsp_data_o, bus.in_rdy_o);
        end
        tests_run++;
        if ({bus.req_rdy_o, bus.mem_val_o, bus.out_val_o, bus.mem_addr_o, bus.mem_wdata_o, bus.out_data_o} !== '0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got rdy=%b mval=%b oval=%b addr=%h wd=%h od=%h, want all 0",
                     bus.req_rdy_o, bus.mem_val_o, bus.out_val_o, bus.mem_addr_o, bus.mem_wdata_o, bus.out_data_o);
        end
        tick();
    endtask

    task automatic test_mem_load();
        idle();
        bus.req_val_i  = 1'b1;
        bus.req_addr_i = 8'h10;
        bus.mem_rdy_i  = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if ({bus.req_rdy_o, bus.mem_val_o, bus.mem_wen_o, bus.mem_addr_o} !== {1'b0, 1'b1, 1'b0, 8'h10}) begin
            tests_failed++;
            $display("FAIL mem_stall: got rdy=%b val=%b wen=%b addr=%h, want 0 1 0 10", bus.req_rdy_o, bus.mem_val_o, bus.mem_wen_o, bus.mem_addr_o);
        end
        tick();
        bus.mem_rdy_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (bus.req_rdy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL mem_accept: got rdy=%b, want 1", bus.req_rdy_o);
        end
        sb_q.push_back('{16'hBEEF, cyc + 1});
        tick();
        idle();
        bus.mem_rdata_i = 16'hBEEF;
        @(negedge clk_i);
        tests_run++;
        if ({bus.rsp_val_o, bus.rsp_data_o, bus.mem_val_o} !== {1'b1, 16'hBEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL mem_rsp: got val=%b data=%h mval=%b, want 1 beef 0", bus.rsp_val_o, bus.rsp_data_o, bus.mem_val_o);
        end
        tick();
        idle();
        @(negedge clk_i);
        tests_run++;
        if (bus.rsp_val_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rsp_pulse: got val=%b, want 0", bus.rsp_val_o);
        end
        tick();
    endtask

    task automatic test_store_stall();
        idle();
        bus.req_val_i  = 1'b1;
        bus.req_wen_i  = 1'b1;
        bus.req_addr_i = 8'hFF;
        bus.req_data_i = 16'h1234;
        bus.out_rdy_i  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            tests_run++;
            if ({bus.req_rdy_o, bus.out_val_o, bus.out_data_o, bus.mem_val_o} !== {1'b0, 2'b01, 16'h0000, 16'h1234, 1'b0}) begin
                tests_failed++;
                $display("FAIL store_stall[%0d]: got rdy=%b oval=%b od=%h mval=%b, want 0 01 00001234 0",
                         i, bus.req_rdy_o, bus.out_val_o, bus.out_data_o, bus.mem_val_o);
            end
            tick();
        end
        bus.out_rdy_i = 2'b11;
        @(negedge clk_i);
        tests_run++;
        if ({bus.req_rdy_o, bus.out_val_o, bus.out_data_o, bus.mem_val_o} !== {1'b1, 2'b01, 16'h0000, 16'h1234, 1'b0}) begin
            tests_failed++;
            $display("FAIL store_accept: got rdy=%b oval=%b od=%h mval=%b, want 1 01 00001234 0",
                     bus.req_rdy_o, bus.out_val_o, bus.out_data_o, bus.mem_val_o);
        end
        tick();
        idle();
        @(negedge clk_i);
        tests_run++;
        if ({bus.out_val_o, bus.out_data_o} !== '0) begin
            tests_failed++;
            $display("FAIL store_idle: got oval=%b od=%h, want 0", bus.out_val_o, bus.out_data_o);
        end
        tick();
    endtask

    task automatic test_fifo_fill();
        idle();
        bus.in_val_i        = 2'b01;
        bus.in_data_i[15:0] = 16'hAAAA;
        @(negedge clk_i);
        tests_run++;
        if (bus.in_rdy_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL fifo_push0: got in_rdy=%b, want 1", bus.in_rdy_o[0]);
        end
        tick();
        bus.in_data_i[15:0] = 16'hBBBB;
        @(negedge clk_i);
        tests_run++;
        if (bus.in_rdy_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL fifo_push1: got in_rdy=%b, want 1", bus.in_rdy_o[0]);
        end
        tick();
        // Full: this push must be refused although a pop happens in the same cycle.
        bus.in_data_i[15:0] = 16'hCCCC;
        bus.req_val_i       = 1'b1;
        bus.req_addr_i      = 8'hFF;
        @(negedge clk_i);
        tests_run++;
        if ({bus.in_rdy_o[0], bus.req_rdy_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL fifo_full: got in_rdy=%b rdy=%b, want 0 1", bus.in_rdy_o[0], bus.req_rdy_o);
        end
        sb_q.push_back('{16'hAAAA, cyc + 1});
        tick();
        bus.in_val_i = 2'b00;
        @(negedge clk_i);
        tests_run++;
        if ({bus.in_rdy_o[0], bus.req_rdy_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL fifo_pop2: got in_rdy=%b rdy=%b, want 1 1", bus.in_rdy_o[0], bus.req_rdy_o);
        end
        sb_q.push_back('{16'hBBBB, cyc + 1});
        tick();
        @(negedge clk_i);
        tests_run++;
        if ({bus.in_rdy_o[0], bus.req_rdy_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL fifo_drained: got in_rdy=%b rdy=%b, want 1 0", bus.in_rdy_o[0], bus.req_rdy_o);
        end
        tick();
        idle();
    endtask

    task automatic test_empty_load_push();
        idle();
        bus.req_val_i       = 1'b1;
        bus.req_addr_i      = 8'hFF;
        bus.in_val_i        = 2'b01;
        bus.in_data_i[15:0] = 16'h0042;
        @(negedge clk_i);
        tests_run++;
        if ({bus.req_rdy_o, bus.in_rdy_o[0]} !== 2'b01) begin
            tests_failed++;
            $display("FAIL no_bypass: got rdy=%b in_rdy=%b, want 0 1", bus.req_rdy_o, bus.in_rdy_o[0]);
        end
        tick();
        bus.in_val_i = 2'b00;
        @(negedge clk_i);
        tests_run++;
        if (bus.req_rdy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL push_then_load: got rdy=%b, want 1", bus.req_rdy_o);
        end
        sb_q.push_back('{16'h0042, cyc + 1});
        tick();
        idle();
        @(negedge clk_i);
        tests_run++;
        if ({bus.rsp_val_o, bus.rsp_data_o} !== {1'b1, 16'h0042}) begin
            tests_failed++;
            $display("FAIL io_rsp: got val=%b data=%h, want 1 0042", bus.rsp_val_o, bus.rsp_data_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.in_val_i         = 2'b10;
        bus.in_data_i[31:16] = 16'h5151;
        tick();
        idle();
        bus.req_val_i  = 1'b1;
        bus.req_addr_i = 8'hFE;
        @(negedge clk_i);
        tests_run++;
        if ({bus.req_rdy_o, bus.mem_val_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL ch1_load: got rdy=%b mval=%b, want 1 0", bus.req_rdy_o, bus.mem_val_o);
        end
        sb_q.push_back('{16'h5151, cyc + 1});
        tick();
        bus.req_addr_i = 8'h20;
        @(negedge clk_i);
        tests_run++;
        if ({bus.req_rdy_o, bus.mem_val_o, bus.mem_addr_o} !== {1'b1, 1'b1, 8'h20}) begin
            tests_failed++;
            $display("FAIL b2b_mem_load: got rdy=%b mval=%b addr=%h, want 1 1 20", bus.req_rdy_o, bus.mem_val_o, bus.mem_addr_o);
        end
        sb_q.push_back('{16'h2020, cyc + 1});
        tick();
        bus.mem_rdata_i = 16'h2020;
        bus.req_wen_i   = 1'b1;
        bus.req_addr_i  = 8'h30;
        bus.req_data_i  = 16'h7777;
        @(negedge clk_i);
        tests_run++;
        if ({bus.req_rdy_o, bus.mem_val_o, bus.mem_wen_o, bus.mem_addr_o, bus.mem_wdata_o, bus.out_val_o} !==
            {1'b1, 1'b1, 1'b1, 8'h30, 16'h7777, 2'b00}) begin
            tests_failed++;
            $display("FAIL mem_store: got rdy=%b mval=%b wen=%b addr=%h wd=%h oval=%b, want 1 1 1 30 7777 00",
                     bus.req_rdy_o, bus.mem_val_o, bus.mem_wen_o, bus.mem_addr_o, bus.mem_wdata_o, bus.out_val_o);
        end
        tick();
        bus.mem_rdata_i = 16'hDEAD;
        bus.req_addr_i  = 8'hFE;
        bus.req_data_i  = 16'h9999;
        @(negedge clk_i);
        tests_run++;
        if ({bus.out_val_o, bus.out_data_o, bus.mem_val_o} !== {2'b10, 16'h9999, 16'h0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL ch1_store: got oval=%b od=%h mval=%b, want 10 99990000 0", bus.out_val_o, bus.out_data_o, bus.mem_val_o);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.in_val_i        = 2'b01;
        bus.in_data_i[15:0] = 16'h1111;
        tick();
        // Reset coincides with a memory load and a channel-1 push; all of it must be lost.
        idle();
        rst_i                = 1'b1;
        bus.req_val_i        = 1'b1;
        bus.req_addr_i       = 8'h10;
        bus.in_val_i         = 2'b10;
        bus.in_data_i[31:16] = 16'h2222;
        tick();
        rst_i = 1'b0;
        idle();
        bus.req_val_i  = 1'b1;
        bus.req_addr_i = 8'hFF;
        @(negedge clk_i);
        tests_run++;
        if ({bus.rsp_val_o, bus.in_rdy_o, bus.req_rdy_o} !== {1'b0, 2'b11, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_ch0: got val=%b in_rdy=%b rdy=%b, want 0 11 0", bus.rsp_val_o, bus.in_rdy_o, bus.req_rdy_o);
        end
        #1;
        bus.req_addr_i = 8'hFE;
        #1;
        tests_run++;
        if (bus.req_rdy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_ch1: got rdy=%b, want 0", bus.req_rdy_o);
        end
        tick();
        // Accept a memory load, then hold reset; nothing may emerge once reset is released.
        bus.req_addr_i = 8'h10;
        tick();
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if ({bus.rsp_val_o, bus.rsp_data_o, bus.in_rdy_o} !== {1'b0, 16'h0000, 2'b11}) begin
            tests_failed++;
            $display("FAIL reset_after_load: got val=%b data=%h in_rdy=%b, want 0 0000 11", bus.rsp_val_o, bus.rsp_data_o, bus.in_rdy_o);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        test_reset();
        test_mem_load();
        test_store_stall();
        test_fifo_fill();
        test_empty_load_push();
        test_back_to_back();
        test_reset_mid();
        tick();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL missing_rsp: got %0d responses outstanding, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
